// File: rtl/buzzer_lockout_arbiter.sv
// Fastest-finger-first front end. Each button is synchronised, debounced and
// edge-detected independently; the first press of an armed round wins and locks out the rest.

module buzzer_lane #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          db;
  logic          db_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
      db   <= 1'b0;
      db_d <= 1'b0;
    end else begin
      sync <= {sync[0], button};
      if (!sync[1])
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
      // db registered off the counter so a stable press lands two edges after the count fills
      db   <= (cnt == CNT_MAX);
      db_d <= db;
    end
  end

  assign press = db & ~db_d;
endmodule

module buzzer_lockout_arbiter #(
  parameter int N_PLAYERS       = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ANSWER_CYCLES   = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  input  logic [N_PLAYERS-1:0] buttons,
  output logic [3:0]           hex,
  output logic                 winner_valid,
  output logic                 armed,
  output logic                 timed_out
);
  localparam int TW = $clog2(ANSWER_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ANSWER_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED, TIMEOUT} state_t;

  state_t               state, state_n;
  logic [TW-1:0]        timer, timer_n;
  logic [3:0]           hex_n;
  logic [N_PLAYERS-1:0] press;
  logic                 hit;
  logic [3:0]           win;

  for (genvar i = 0; i < N_PLAYERS; i++) begin : g_lane
    buzzer_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .button (buttons[i]),
      .press  (press[i])
    );
  end

  // Scan high to low so the lowest simultaneous index is the one left standing
  always_comb begin
    hit = 1'b0;
    win = 4'd0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (press[i]) begin
        hit = 1'b1;
        win = 4'(i + 1);
      end
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    hex_n   = hex;
    if (clear) begin
      state_n = IDLE;
      timer_n = '0;
      hex_n   = 4'd0;
    end else begin
      unique case (state)
        IDLE, LOCKED, TIMEOUT: begin
          if (start) begin
            state_n = ARMED;
            timer_n = '0;
            hex_n   = 4'd0;
          end
        end
        ARMED: begin
          if (start) begin
            timer_n = '0;
          end else if (hit) begin
            state_n = LOCKED;
            hex_n   = win;
          end else if (timer == TIMER_LAST) begin
            state_n = TIMEOUT;
            timer_n = '0;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          timer_n = '0;
          hex_n   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      hex          <= 4'd0;
      winner_valid <= 1'b0;
      armed        <= 1'b0;
      timed_out    <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      hex          <= hex_n;
      winner_valid <= (state_n == LOCKED);
      armed        <= (state_n == ARMED);
      timed_out    <= (state_n == TIMEOUT);
    end
  end
endmodule

// File: tb/tb_buzzer_lockout_arbiter.sv
// Bench for buzzer_lockout_arbiter: directed scenarios then random traffic, with a
// round-outcome scoreboard fed by an edge-indexed behavioural model.

module tb_buzzer_lockout_arbiter;
  localparam int N = 4;
  localparam int D = 16;
  localparam int A = 1000;
  localparam int MAXE = 60000;
  localparam int M_IDLE = 0, M_ARMED = 1, M_LOCKED = 2, M_TIMEOUT = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         clear = 1'b0;
  logic [N-1:0] buttons = '0;
  logic [3:0]   hex;
  logic         winner_valid, armed, timed_out;

  always #5 clk = ~clk;

  buzzer_lockout_arbiter #(.N_PLAYERS(N), .DEBOUNCE_CYCLES(D), .ANSWER_CYCLES(A)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .clear        (clear),
    .buttons      (buttons),
    .hex          (hex),
    .winner_valid (winner_valid),
    .armed        (armed),
    .timed_out    (timed_out)
  );

  typedef struct {
    int t;
    bit to;
    int hx;
  } ev_t;

  ev_t          exp_q[$];
  int           checks = 0;
  int           passes = 0;
  int           edge_n = 0;
  int           last_ev_edge = 0;
  int           mode = M_IDLE;
  int           arm_edge = 0;
  int           rl[N];
  bit [N-1:0]   sched [0:MAXE];

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_n);
  endfunction

  function automatic void model_reset();
    mode = M_IDLE;
    arm_edge = 0;
    for (int i = 0; i < N; i++) rl[i] = 0;
    for (int t = edge_n; t <= MAXE; t++) sched[t] = '0;
    exp_q.delete();
  endfunction

  // A press counts once D consecutive high samples are seen; it reaches the
  // round logic four edges after the D-th sample.
  function automatic void model_edge(bit s, bit c, logic [N-1:0] b);
    logic [N-1:0] p;
    int w;
    ev_t e;
    for (int i = 0; i < N; i++) begin
      if (b[i]) begin
        rl[i]++;
        if (rl[i] == D && edge_n + 4 <= MAXE) sched[edge_n + 4][i] = 1'b1;
      end else rl[i] = 0;
    end
    p = (edge_n <= MAXE) ? sched[edge_n] : '0;
    w = 0;
    for (int i = N - 1; i >= 0; i--) if (p[i]) w = i + 1;
    if (c) mode = M_IDLE;
    else if (mode == M_ARMED) begin
      if (s) arm_edge = edge_n;
      else if (w != 0) begin
        mode = M_LOCKED;
        e.t = edge_n; e.to = 1'b0; e.hx = w;
        exp_q.push_back(e);
      end else if (edge_n - arm_edge == A) begin
        mode = M_TIMEOUT;
        e.t = edge_n; e.to = 1'b1; e.hx = 0;
        exp_q.push_back(e);
      end
    end else if (s) begin
      mode = M_ARMED;
      arm_edge = edge_n;
    end
  endfunction

  task automatic step(bit s, bit c, logic [N-1:0] b);
    start = s;
    clear = c;
    buttons = b;
    @(posedge clk);
    edge_n++;
    if (!rst) model_edge(s, c, b);
    #1;
  endtask

  // Monitor: a rising winner_valid or timed_out is a round outcome to score
  bit wv_q = 1'b0, to_q = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      wv_q = 1'b0;
      to_q = 1'b0;
    end else begin
      if ((winner_valid && !wv_q) || (timed_out && !to_q)) begin
        last_ev_edge = edge_n;
        if (exp_q.size() == 0) chk("unexpected_outcome", 1, 0);
        else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("outcome_kind", int'(timed_out), int'(e.to));
          chk("outcome_edge", edge_n, e.t);
          chk("outcome_hex", int'(hex), e.hx);
          chk("outcome_armed", int'(armed), 0);
        end
      end
      if (exp_q.size() > 0 && exp_q[0].t < edge_n) begin
        chk("missed_outcome_edge", edge_n, exp_q[0].t);
        void'(exp_q.pop_front());
      end
      wv_q = winner_valid;
      to_q = timed_out;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
    $fatal(1);
  end

  initial begin
    int k;
    int dw[N];
    logic [N-1:0] bh;
    bit s, c;

    for (int i = 0; i < N; i++) rl[i] = 0;
    repeat (3) step(0, 0, '0);
    chk("reset_hex", int'(hex), 0);
    chk("reset_winner_valid", int'(winner_valid), 0);
    chk("reset_armed", int'(armed), 0);
    chk("reset_timed_out", int'(timed_out), 0);
    rst = 1'b0;
    model_reset();

    // 1: single press, fixed latency
    step(1, 0, '0);
    chk("t1_armed", int'(armed), 1);
    k = edge_n + 1;
    repeat (25) step(0, 0, 4'b0100);
    chk("t1_hex", int'(hex), 3);
    chk("t1_winner_valid", int'(winner_valid), 1);
    chk("t1_armed_after", int'(armed), 0);
    chk("t1_latency", last_ev_edge - k, 19);

    // 2: lockout, then re-arm
    repeat (50) step(0, 0, 4'b0001);
    chk("t2_hex_held", int'(hex), 3);
    chk("t2_winner_held", int'(winner_valid), 1);
    step(1, 0, 4'b0001);
    step(0, 0, '0);
    chk("t2_rearm_armed", int'(armed), 1);
    chk("t2_rearm_hex", int'(hex), 0);
    chk("t2_rearm_winner", int'(winner_valid), 0);

    // 3: simultaneous press, lowest index wins
    repeat (10) step(0, 0, '0);
    repeat (25) step(0, 0, 4'b1010);
    chk("t3_hex", int'(hex), 2);

    // 4: short glitch, then window expiry
    step(1, 0, '0);
    k = edge_n;
    for (int i = 0; i < 1005; i++) step(0, 0, (i < 10) ? 4'b0001 : 4'b0000);
    chk("t4_timed_out", int'(timed_out), 1);
    chk("t4_hex", int'(hex), 0);
    chk("t4_winner", int'(winner_valid), 0);
    chk("t4_window", last_ev_edge - k, A);

    // 5: button held through arming never wins until re-pressed
    repeat (30) step(0, 0, 4'b0010);
    step(1, 0, 4'b0010);
    repeat (30) step(0, 0, 4'b0010);
    chk("t5_held_no_winner", int'(winner_valid), 0);
    chk("t5_still_armed", int'(armed), 1);
    repeat (20) step(0, 0, '0);
    repeat (25) step(0, 0, 4'b0010);
    chk("t5_repress_hex", int'(hex), 2);

    // 6: async reset mid-debounce, then clear beats start
    step(1, 0, '0);
    repeat (8) step(0, 0, 4'b0001);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_armed", int'(armed), 0);
    chk("t6_rst_hex", int'(hex), 0);
    chk("t6_rst_winner", int'(winner_valid), 0);
    chk("t6_rst_timed_out", int'(timed_out), 0);
    repeat (2) step(0, 0, '0);
    rst = 1'b0;
    model_reset();
    step(1, 0, '0);
    chk("t6_armed_before_clear", int'(armed), 1);
    step(1, 1, '0);
    chk("t6_clear_start_armed", int'(armed), 0);
    chk("t6_clear_start_hex", int'(hex), 0);
    step(0, 0, '0);
    chk("t6_idle_holds", int'(armed), 0);

    // Random traffic: glitches shorter and longer than the debounce length
    bh = '0;
    for (int i = 0; i < N; i++) dw[i] = $urandom_range(30, 500);
    for (int n = 0; n < 30000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (dw[i] == 0) begin
          bh[i] = ~bh[i];
          dw[i] = bh[i] ? $urandom_range(1, 40) : $urandom_range(30, 500);
        end
        dw[i]--;
      end
      s = (mode == M_ARMED) ? ($urandom_range(0, 399) == 0) : ($urandom_range(0, 29) == 0);
      c = ($urandom_range(0, 1999) == 0);
      step(s, c, bh);
    end
    repeat (30) step(1'b0, 1'b1, '0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
